// File: rtl/radio_ser_pkg.sv
// Shared helpers and types for the radio serializer/deserializer pair.
package radio_ser_pkg;

  // Number of chunks needed to carry one word (ceiling division).
  function automatic int unsigned calc_no_cyc(input int unsigned bw_word,
                                              input int unsigned bw_chunk);
    return (bw_word + bw_chunk - 1) / bw_chunk;
  endfunction

  // Counter width for n states, never narrower than one bit.
  function automatic int unsigned calc_cnt_w(input int unsigned n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/to_parallel_ch.sv
// One channel of the deserializer: chunk shift register plus truncation.
module to_parallel_ch
  import radio_ser_pkg::*;
#(
  parameter int unsigned BW_IN  = 2,
  parameter int unsigned BW_OUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_i,
  input  logic [BW_IN-1:0]  chunk_i,
  output logic [BW_OUT-1:0] word_o
);

  localparam int unsigned NO_CYC = calc_no_cyc(BW_OUT, BW_IN);
  localparam int unsigned SR_W   = NO_CYC * BW_IN;

  logic [SR_W-1:0] sr_q, sr_d, sr_ins;

  // Value after inserting the new chunk at the top; with a single chunk per
  // word the register is just the chunk itself.
  generate
    if (NO_CYC == 1) begin : g_single
      assign sr_ins = chunk_i;
    end else begin : g_multi
      assign sr_ins = {chunk_i, sr_q[SR_W-1:BW_IN]};
    end
  endgenerate

  // Shift only on accepted chunks; gaps hold the partial word.
  always_comb begin
    sr_d = sr_q;
    if (shift_i) sr_d = sr_ins;
  end

  // Completed word is taken from the post-insert value so it can load the
  // output register on the same edge as the last chunk.
  assign word_o = sr_ins[BW_OUT-1:0];

  // Shift register storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr_q <= '0;
    else     sr_q <= sr_d;
  end

endmodule

// File: rtl/to_parallel.sv
// Receive-side deserializer: reassembles NO_CH channels of BW_IN-bit chunks
// into BW_OUT-bit words behind a valid/ready output register.
module to_parallel
  import radio_ser_pkg::*;
#(
  parameter int unsigned NO_CH  = 10,
  parameter int unsigned BW_IN  = 2,
  parameter int unsigned BW_OUT = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          vld_in,
  input  logic                          align,
  input  logic [NO_CH-1:0][BW_IN-1:0]   data_in,
  input  logic                          rdy_in,
  input  logic                          clr_ovf,
  output logic                          vld_out,
  output logic [NO_CH-1:0][BW_OUT-1:0]  data_out,
  output logic                          ovf
);

  localparam int unsigned NO_CYC = calc_no_cyc(BW_OUT, BW_IN);
  localparam int unsigned CNT_W  = calc_cnt_w(NO_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NO_CYC - 1);

  logic [CNT_W-1:0]                cnt_q, cnt_d, cnt_base;
  out_state_t                      state_q, state_d;
  logic [NO_CH-1:0][BW_OUT-1:0]    data_q, data_d;
  logic                            ovf_q, ovf_d;
  logic [NO_CH-1:0][BW_OUT-1:0]    word_w;
  logic                            complete;
  logic                            drop;

  genvar g;
  generate
    for (g = 0; g < NO_CH; g++) begin : g_ch
      to_parallel_ch #(
        .BW_IN  (BW_IN),
        .BW_OUT (BW_OUT)
      ) u_ch (
        .clk     (clk),
        .rst     (rst),
        .shift_i (vld_in),
        .chunk_i (data_in[g]),
        .word_o  (word_w[g])
      );
    end
  endgenerate

  // Chunk counter: align restarts the word, and a chunk arriving with align
  // is treated as chunk 0. Wrap is explicit at NO_CYC-1.
  always_comb begin
    cnt_base = align ? '0 : cnt_q;
    complete = vld_in && (cnt_base == CNT_LAST);
    cnt_d    = cnt_base;
    if (vld_in) cnt_d = complete ? '0 : cnt_base + CNT_W'(1);
  end

  // Output register FSM: load on completion, release on handshake, drop and
  // flag overflow when a word completes into a stalled full register.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    drop    = 1'b0;
    unique case (state_q)
      OUT_EMPTY: begin
        if (complete) begin
          data_d  = word_w;
          state_d = OUT_FULL;
        end
      end
      OUT_FULL: begin
        if (complete) begin
          if (rdy_in) data_d = word_w;
          else        drop   = 1'b1;
        end else if (rdy_in) begin
          state_d = OUT_EMPTY;
        end
      end
      default: state_d = OUT_EMPTY;
    endcase
    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      state_q <= OUT_EMPTY;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign vld_out  = (state_q == OUT_FULL);
  assign data_out = data_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_to_parallel.sv
// Directed bench for to_parallel with NO_CH=2, BW_IN=2, BW_OUT=8.
module tb_to_parallel;

  localparam int unsigned NO_CH  = 2;
  localparam int unsigned BW_IN  = 2;
  localparam int unsigned BW_OUT = 8;

  logic                         clk;
  logic                         rst;
  logic                         vld_in;
  logic                         align;
  logic [NO_CH-1:0][BW_IN-1:0]  data_in;
  logic                         rdy_in;
  logic                         clr_ovf;
  logic                         vld_out;
  logic [NO_CH-1:0][BW_OUT-1:0] data_out;
  logic                         ovf;

  int unsigned n_chk;
  int unsigned n_pass;

  to_parallel #(
    .NO_CH  (NO_CH),
    .BW_IN  (BW_IN),
    .BW_OUT (BW_OUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .vld_in   (vld_in),
    .align    (align),
    .data_in  (data_in),
    .rdy_in   (rdy_in),
    .clr_ovf  (clr_ovf),
    .vld_out  (vld_out),
    .data_out (data_out),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Drive one cycle at the falling edge, then wait for the next falling edge
  // so outputs reflect the intervening rising edge.
  task automatic cyc(input logic v, input logic [1:0] c0, input logic [1:0] c1,
                     input logic r, input logic a, input logic clr);
    vld_in     = v;
    data_in[0] = c0;
    data_in[1] = c1;
    rdy_in     = r;
    align      = a;
    clr_ovf    = clr;
    @(negedge clk);
  endtask

  function automatic logic [1:0] chunk(input logic [7:0] w, input int unsigned k);
    logic [7:0] s;
    s = w >> (2 * k);
    return s[1:0];
  endfunction

  // Send one chunk of each word.
  task automatic send_chunk(input logic [7:0] w0, input logic [7:0] w1,
                            input int unsigned k, input logic r, input logic a);
    cyc(1'b1, chunk(w0, k), chunk(w1, k), r, a, 1'b0);
  endtask

  task automatic send_word(input logic [7:0] w0, input logic [7:0] w1, input logic r);
    for (int unsigned k = 0; k < 4; k++) send_chunk(w0, w1, k, r, 1'b0);
  endtask

  task automatic idle(input logic r);
    cyc(1'b0, 2'd0, 2'd0, r, 1'b0, 1'b0);
  endtask

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    rst     = 1'b1;
    vld_in  = 1'b0;
    align   = 1'b0;
    data_in = '0;
    rdy_in  = 1'b0;
    clr_ovf = 1'b0;

    #12;
    check("rst_vld",  {31'd0, vld_out}, 32'd0);
    check("rst_data", {16'd0, data_out}, 32'd0);
    check("rst_ovf",  {31'd0, ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single word, ch0 chunks 0,1,3,2 -> 0xB4; ch1 chunks 2,2,1,1 -> 0x5A.
    for (int unsigned k = 0; k < 4; k++) begin
      send_chunk(8'hB4, 8'h5A, k, 1'b1, 1'b0);
      if (k < 3) check("single_early_vld", {31'd0, vld_out}, 32'd0);
    end
    check("single_vld", {31'd0, vld_out}, 32'd1);
    check("single_d0",  {24'd0, data_out[0]}, 32'hB4);
    check("single_d1",  {24'd0, data_out[1]}, 32'h5A);
    check("single_ovf", {31'd0, ovf}, 32'd0);
    idle(1'b1);
    check("single_pulse_end", {31'd0, vld_out}, 32'd0);

    // Gapped chunks: two idle cycles after each chunk.
    for (int unsigned k = 0; k < 4; k++) begin
      send_chunk(8'hB4, 8'h5A, k, 1'b1, 1'b0);
      if (k < 3) begin
        check("gap_early_vld", {31'd0, vld_out}, 32'd0);
      end else begin
        check("gap_vld", {31'd0, vld_out}, 32'd1);
        check("gap_d0",  {24'd0, data_out[0]}, 32'hB4);
        check("gap_d1",  {24'd0, data_out[1]}, 32'h5A);
      end
      for (int unsigned j = 0; j < 2; j++) begin
        idle(1'b1);
        check("gap_idle_vld", {31'd0, vld_out}, 32'd0);
      end
    end

    // Back-pressure: A held, B dropped, ovf sticky until cleared.
    send_word(8'hB4, 8'h5A, 1'b0);
    check("bp_a_vld", {31'd0, vld_out}, 32'd1);
    check("bp_a_ovf", {31'd0, ovf}, 32'd0);
    send_word(8'h0F, 8'hF0, 1'b0);
    check("bp_b_vld", {31'd0, vld_out}, 32'd1);
    check("bp_keep_d0", {24'd0, data_out[0]}, 32'hB4);
    check("bp_keep_d1", {24'd0, data_out[1]}, 32'h5A);
    check("bp_ovf_set", {31'd0, ovf}, 32'd1);
    idle(1'b1);
    check("bp_release_vld", {31'd0, vld_out}, 32'd0);
    check("bp_ovf_sticky", {31'd0, ovf}, 32'd1);
    cyc(1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1);
    check("bp_ovf_clr", {31'd0, ovf}, 32'd0);

    // Consume A on exactly the edge B completes.
    send_word(8'hB4, 8'h5A, 1'b0);
    for (int unsigned k = 0; k < 3; k++) send_chunk(8'h0F, 8'hF0, k, 1'b0, 1'b0);
    check("sim_pending_d0", {24'd0, data_out[0]}, 32'hB4);
    send_chunk(8'h0F, 8'hF0, 3, 1'b1, 1'b0);
    check("sim_vld", {31'd0, vld_out}, 32'd1);
    check("sim_d0",  {24'd0, data_out[0]}, 32'h0F);
    check("sim_d1",  {24'd0, data_out[1]}, 32'hF0);
    check("sim_ovf", {31'd0, ovf}, 32'd0);
    idle(1'b1);
    check("sim_end_vld", {31'd0, vld_out}, 32'd0);

    // Align mid-word: two garbage chunks, then realign with chunk 0.
    cyc(1'b1, 2'd3, 2'd1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 2'd3, 2'd1, 1'b1, 1'b0, 1'b0);
    check("align_garbage_vld", {31'd0, vld_out}, 32'd0);
    send_chunk(8'hB4, 8'h5A, 0, 1'b1, 1'b1);
    check("align_c0_vld", {31'd0, vld_out}, 32'd0);
    for (int unsigned k = 1; k < 4; k++) begin
      send_chunk(8'hB4, 8'h5A, k, 1'b1, 1'b0);
      if (k < 3) check("align_early_vld", {31'd0, vld_out}, 32'd0);
    end
    check("align_vld", {31'd0, vld_out}, 32'd1);
    check("align_d0",  {24'd0, data_out[0]}, 32'hB4);
    check("align_d1",  {24'd0, data_out[1]}, 32'h5A);
    idle(1'b1);
    check("align_end_vld", {31'd0, vld_out}, 32'd0);

    // Async reset while FULL, with ovf set and a partial word in flight.
    send_word(8'h0F, 8'hF0, 1'b0);
    send_word(8'hB4, 8'h5A, 1'b0);
    send_chunk(8'h0F, 8'hF0, 0, 1'b0, 1'b0);
    send_chunk(8'h0F, 8'hF0, 1, 1'b0, 1'b0);
    check("prerst_vld", {31'd0, vld_out}, 32'd1);
    check("prerst_ovf", {31'd0, ovf}, 32'd1);
    vld_in = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("arst_vld",  {31'd0, vld_out}, 32'd0);
    check("arst_data", {16'd0, data_out}, 32'd0);
    check("arst_ovf",  {31'd0, ovf}, 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int unsigned k = 0; k < 4; k++) begin
      send_chunk(8'hB4, 8'h5A, k, 1'b1, 1'b0);
      if (k < 3) check("post_rst_early_vld", {31'd0, vld_out}, 32'd0);
    end
    check("post_rst_vld", {31'd0, vld_out}, 32'd1);
    check("post_rst_d0",  {24'd0, data_out[0]}, 32'hB4);
    check("post_rst_d1",  {24'd0, data_out[1]}, 32'h5A);
    idle(1'b1);
    check("post_rst_end_vld", {31'd0, vld_out}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
